// File: rtl/program_loader_if.sv
// Byte-stream and instruction-memory write signals for program_loader.
// The loader takes the slave modport; the stream source and memory take the master side.
interface program_loader_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  Start;
  logic [7:0]            ByteIn;
  logic                  ByteValid;
  logic                  ByteReady;
  logic                  WriteEnable;
  logic [DATA_WIDTH-1:0] WriteAddress;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  CoreHold;
  logic                  Done;
  logic                  Overflow;
  logic                  ChecksumError;

  modport master (
    output Start,
    output ByteIn,
    output ByteValid,
    input  ByteReady,
    input  WriteEnable,
    input  WriteAddress,
    input  WriteData,
    input  CoreHold,
    input  Done,
    input  Overflow,
    input  ChecksumError
  );

  modport slave (
    input  Start,
    input  ByteIn,
    input  ByteValid,
    output ByteReady,
    output WriteEnable,
    output WriteAddress,
    output WriteData,
    output CoreHold,
    output Done,
    output Overflow,
    output ChecksumError
  );
endinterface

// File: rtl/program_loader.sv
// Length-prefixed little-endian byte stream to instruction-RAM word writer; stalls the core
// while loading. Define LOADER_CHECKSUM_EN to expect and verify a 4-byte sum trailer.
module program_loader #(
  parameter int unsigned           MEMORY_DEPTH = 32,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h0040_0000
) (
  input logic             clk,
  input logic             reset,
  program_loader_if.slave bus
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    StIdle, StHeader, StLoad, StWrite, StCheck, StDone
  } state_e;
  localparam state_e StAfterPayload = StCheck;
`else
  typedef enum logic [2:0] {
    StIdle, StHeader, StLoad, StWrite, StDone
  } state_e;
  localparam state_e StAfterPayload = StDone;
`endif

  localparam logic [DATA_WIDTH-1:0] Depth = DATA_WIDTH'(MEMORY_DEPTH);

  state_e                state_q, state_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [DATA_WIDTH-1:0] word_idx_q, word_idx_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic                  ready_q, ready_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic                  cerr_q, cerr_d;

  logic                  fire;
  logic                  last_byte;
  logic [DATA_WIDTH-1:0] assembled;
  logic [DATA_WIDTH-1:0] idx_inc;

  assign fire      = bus.ByteValid && ready_q;
  assign last_byte = fire && (byte_idx_q == 2'd3);
  // Bytes enter at the top and shift down, so the first byte ends up in bits 7:0.
  assign assembled = {bus.ByteIn, shift_q[DATA_WIDTH-1:8]};
  assign idx_inc   = word_idx_q + DATA_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    count_d    = count_q;
    shift_d    = shift_q;
    sum_d      = sum_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    ovf_d      = ovf_q;
    cerr_d     = cerr_q;

    if (fire) begin
      shift_d    = assembled;
      byte_idx_d = byte_idx_q + 2'd1;
    end

    case (state_q)
      StIdle, StDone: begin
        if (bus.Start) begin
          ovf_d      = 1'b0;
          cerr_d     = 1'b0;
          byte_idx_d = 2'd0;
          word_idx_d = '0;
          sum_d      = '0;
          state_d    = StHeader;
        end
      end
      StHeader: begin
        if (last_byte) begin
          count_d = assembled;
          if (assembled > Depth) ovf_d = 1'b1;
          state_d = (assembled == '0) ? StAfterPayload : StLoad;
        end
      end
      StLoad: begin
        if (last_byte) begin
          // Words past the memory depth are still consumed, just never strobed.
          we_d    = (word_idx_q < Depth);
          waddr_d = BASE_ADDRESS + (word_idx_q << 2);
          wdata_d = assembled;
          state_d = StWrite;
        end
      end
      StWrite: begin
        sum_d      = sum_q + wdata_q;
        word_idx_d = idx_inc;
        state_d    = (idx_inc == count_q) ? StAfterPayload : StLoad;
      end
`ifdef LOADER_CHECKSUM_EN
      StCheck: begin
        if (last_byte) begin
          if (assembled != sum_q) cerr_d = 1'b1;
          state_d = StDone;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    // Status outputs are registered copies of what the next state implies.
    ready_d = (state_d == StHeader) || (state_d == StLoad)
`ifdef LOADER_CHECKSUM_EN
              || (state_d == StCheck)
`endif
              ;
    hold_d  = (state_d != StIdle) && (state_d != StDone);
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      byte_idx_q <= 2'd0;
      word_idx_q <= '0;
      count_q    <= '0;
      shift_q    <= '0;
      sum_q      <= '0;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      cerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      sum_q      <= sum_d;
      ready_q    <= ready_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      cerr_q     <= cerr_d;
    end
  end

  assign bus.ByteReady     = ready_q;
  assign bus.WriteEnable   = we_q;
  assign bus.WriteAddress  = waddr_q;
  assign bus.WriteData     = wdata_q;
  assign bus.CoreHold      = hold_q;
  assign bus.Done          = done_q;
  assign bus.Overflow      = ovf_q;
  assign bus.ChecksumError = cerr_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: streams built from word lists, expected writes and
// flags derived from the stream-format rules, writes captured by a monitor and compared.
module tb_program_loader;
  localparam int unsigned Depth = 32;
  localparam logic [31:0] Base  = 32'h0040_0000;

  logic clk = 1'b0;
  logic reset;

  program_loader_if #(.DATA_WIDTH(32)) lif ();

  program_loader #(
    .MEMORY_DEPTH(Depth),
    .DATA_WIDTH  (32),
    .BASE_ADDRESS(Base)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (lif)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] words[$];
  logic [7:0]  stream[$];
  logic [31:0] exp_addr[$], exp_data[$];
  logic [31:0] act_addr[$], act_data[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Capture every write strobe; the loader must not be accepting bytes while it writes.
  always @(negedge clk) begin
    if (lif.WriteEnable === 1'b1) begin
      act_addr.push_back(lif.WriteAddress);
      act_data.push_back(lif.WriteData);
      check("ready_low_in_write", 32'(lif.ByteReady), 32'd0);
    end
  end

  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) stream.push_back(w[8*k +: 8]);
  endtask

  task automatic pulse_start();
    lif.Start = 1'b1;
    @(posedge clk);
    #1;
    lif.Start = 1'b0;
  endtask

  // Offer stream[0..count-1] with random ByteValid gaps; a byte advances only when accepted.
  task automatic send_bytes(input int count, input int gap_pct);
    int  i     = 0;
    int  guard = 0;
    bit  fire;
    while (i < count && guard < 4000) begin
      lif.ByteIn    = stream[i];
      lif.ByteValid = ($urandom_range(99) >= gap_pct);
      @(negedge clk);
      fire = lif.ByteValid && lif.ByteReady;
      @(posedge clk);
      #1;
      if (fire) i++;
      guard++;
    end
    lif.ByteValid = 1'b0;
    check("stream_consumed", i, count);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, 32'(lif.ByteReady), 0);
    check({tag, "_we"}, 32'(lif.WriteEnable), 0);
    check({tag, "_waddr"}, lif.WriteAddress, 0);
    check({tag, "_wdata"}, lif.WriteData, 0);
    check({tag, "_hold"}, 32'(lif.CoreHold), 0);
    check({tag, "_done"}, 32'(lif.Done), 0);
    check({tag, "_ovf"}, 32'(lif.Overflow), 0);
    check({tag, "_cerr"}, 32'(lif.ChecksumError), 0);
  endtask

  task automatic run_load(input int gap_pct, input bit bad_trailer);
    logic [31:0] sum = 0;
    bit          exp_ovf;
    bit          exp_cerr = 1'b0;
    int          g = 0;
    int          n;
    stream   = {};
    exp_addr = {};
    exp_data = {};
    push_word(words.size());
    foreach (words[i]) begin
      push_word(words[i]);
      sum += words[i];
      if (i < Depth) begin
        exp_addr.push_back(Base + 32'(4 * i));
        exp_data.push_back(words[i]);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    push_word(bad_trailer ? 32'h0 : sum);
    exp_cerr = bad_trailer && (sum != 0);
`endif
    exp_ovf = (words.size() > Depth);

    pulse_start();
    act_addr = {};
    act_data = {};
    check("hold_after_start", 32'(lif.CoreHold), 1);
    check("done_cleared", 32'(lif.Done), 0);
    check("ovf_cleared", 32'(lif.Overflow), 0);
    check("cerr_cleared", 32'(lif.ChecksumError), 0);

    send_bytes(stream.size(), gap_pct);
`ifndef LOADER_CHECKSUM_EN
    if (words.size() == 0) check("done_after_header", 32'(lif.Done), 1);
`endif
    while (lif.Done !== 1'b1 && g < 20) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("done", 32'(lif.Done), 1);
    check("hold_released", 32'(lif.CoreHold), 0);
    check("overflow", 32'(lif.Overflow), 32'(exp_ovf));
    check("checksum_error", 32'(lif.ChecksumError), 32'(exp_cerr));
    check("write_count", act_addr.size(), exp_addr.size());
    n = (act_addr.size() < exp_addr.size()) ? act_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check("write_addr", act_addr[i], exp_addr[i]);
      check("write_data", act_data[i], exp_data[i]);
    end
  endtask

  initial begin
    reset         = 1'b1;
    lif.Start     = 1'b0;
    lif.ByteIn    = 8'h00;
    lif.ByteValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    words = {32'h0000_0013, 32'h0040_0008};
    run_load(0, 1'b0);
    run_load(50, 1'b0);

    words = {};
    run_load(30, 1'b0);

    words = {};
    for (int i = 0; i < 33; i++) words.push_back($urandom);
    run_load(20, 1'b0);

    // Reset halfway through the first payload word.
    stream = {};
    push_word(32'd2);
    push_word(32'h0000_0013);
    pulse_start();
    send_bytes(6, 0);
    check("ready_mid_word", 32'(lif.ByteReady), 1);
    #2;
    reset = 1'b1;
    #1;
    check_outputs_zero("mid_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    words = {32'h0000_0013, 32'h0040_0008};
    run_load(0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      int n = $urandom_range(10, 1);
      words = {};
      for (int i = 0; i < n; i++) words.push_back($urandom);
      run_load($urandom_range(60), 1'b0);
    end

`ifdef LOADER_CHECKSUM_EN
    words = {32'h0000_0013, 32'h0040_0008};
    run_load(0, 1'b1);
    run_load(10, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
